// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux_pkg
//  Description : Shared encodings for the arb_mux arbitrating multiplexer:
//                arbitration mode values and output-register FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_mux_pkg;

    // Arbitration mode, as driven on the 'mode' input
    localparam logic c_MODE_FIXED = 1'b0;
    localparam logic c_MODE_RR    = 1'b1;

    // Output register occupancy
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage : arb_mux_pkg
`default_nettype wire

// File: rtl/arb_mux_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Round-robin priority picker. Returns the first set bit of
//                'valid' found by searching upward from 'ptr', wrapping from
//                NCH-1 back to 0.
//  Ports       : valid [NCH-1:0] in  - request vector
//                ptr   [IW-1:0]  in  - search start position
//                found           out - any request present
//                idx   [IW-1:0]  out - winning channel (0 when !found)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NCH = 4,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] valid,
    input  logic [IW-1:0]  ptr,
    output logic           found,
    output logic [IW-1:0]  idx
);

    // Walk offsets from the farthest to the nearest so the nearest match
    // (lowest offset from ptr) is the last one written and therefore wins.
    always_comb begin
        int v_c;
        found = 1'b0;
        idx   = '0;
        v_c   = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            v_c = int'(ptr) + k;
            if (v_c >= NCH) begin
                v_c = v_c - NCH;
            end
            if (valid[v_c[IW-1:0]]) begin
                found = 1'b1;
                idx   = v_c[IW-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux
//  Description : NCH-channel valid/ready arbitrating multiplexer with a
//                single registered output slot. Fixed-select or round-robin
//                arbitration; full throughput when downstream is ready.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                in_data/in_valid/in_ready - per-channel input handshake,
//                                  channel i at in_data[i*WIDTH +: WIDTH]
//                sel, mode       - fixed channel select / 0=fixed 1=rr
//                out_data/out_chan/out_valid/out_ready - output handshake
//                xfer_cnt        - 16-bit output handshake counter
//                                  (only when ARB_MUX_CNT_EN is defined)
//  Config      : `define ARB_MUX_CNT_EN to add the xfer_cnt counter/port.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH*WIDTH-1:0]     in_data,
    input  logic [NCH-1:0]           in_valid,
    output logic [NCH-1:0]           in_ready,
    input  logic [$clog2(NCH)-1:0]   sel,
    input  logic                     mode,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(NCH)-1:0]   out_chan,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef ARB_MUX_CNT_EN
    ,
    output logic [15:0]              xfer_cnt
`endif
);

    localparam int c_IW = $clog2(NCH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_data;
    logic [c_IW-1:0]     r_chan;
    logic [c_IW-1:0]     r_rr_ptr;

    logic                w_load;
    logic                w_fix_vld;
    logic                w_rr_found;
    logic [c_IW-1:0]     w_rr_idx;
    logic                w_gnt_vld;
    logic [c_IW-1:0]     w_gnt_idx;
    logic                w_xfer;
    logic [WIDTH-1:0]    w_chan_data [NCH];

    // ------------------------------------------------------------------
    // Unpack the flat input bus into per-channel words
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NCH; i++) begin : g_unpack
            assign w_chan_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign out_valid = (r_state == ST_FULL);
    assign w_load    = ~out_valid | out_ready;

    // A select value beyond the last channel (possible when NCH is not a
    // power of two) grants nothing.
    always_comb begin
        w_fix_vld = 1'b0;
        if (int'(sel) < NCH) begin
            w_fix_vld = in_valid[sel];
        end
    end

    rr_pick #(
        .NCH (NCH),
        .IW  (c_IW)
    ) u_rr_pick (
        .valid (in_valid),
        .ptr   (r_rr_ptr),
        .found (w_rr_found),
        .idx   (w_rr_idx)
    );

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (mode == c_MODE_RR) begin
            w_gnt_vld = w_rr_found;
            w_gnt_idx = w_rr_idx;
        end else begin
            w_gnt_vld = w_fix_vld;
            w_gnt_idx = sel;
        end
    end

    // Nothing is accepted while reset is asserted, so a word offered in a
    // reset cycle is never lost silently upstream.
    assign w_xfer = w_load & w_gnt_vld & ~rst;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ready
            assign in_ready[i] = w_xfer & (w_gnt_idx == c_IW'(i));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                // Drain without refill empties; drain with refill stays full.
                if (out_ready && !w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Output data path and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_chan   <= '0;
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_data   <= w_chan_data[w_gnt_idx];
            r_chan   <= w_gnt_idx;
            // Pointer follows every transfer, fixed mode included, so a
            // later switch to round-robin starts after the last winner.
            r_rr_ptr <= (w_gnt_idx == c_IW'(NCH - 1)) ? '0 : w_gnt_idx + c_IW'(1);
        end
    end

    assign out_data = r_data;
    assign out_chan = r_chan;

`ifdef ARB_MUX_CNT_EN
    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (out_valid && out_ready) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_cnt;
`endif

endmodule : arb_mux
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_mux
//  Description : Self-checking bench for arb_mux. A behavioural model of the
//                output slot, grant rules and round-robin pointer predicts
//                in_ready each cycle and the output register after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int IW    = $clog2(NCH);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NCH*WIDTH-1:0]   in_data;
    logic [NCH-1:0]         in_valid;
    logic [NCH-1:0]         in_ready;
    logic [IW-1:0]          sel;
    logic                   mode;
    logic [WIDTH-1:0]       out_data;
    logic [IW-1:0]          out_chan;
    logic                   out_valid;
    logic                   out_ready;
`ifdef ARB_MUX_CNT_EN
    logic [15:0]            xfer_cnt;
`endif

    arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ARB_MUX_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit              m_valid;
    logic [WIDTH-1:0] m_data;
    int              m_chan;
    int              m_ptr;
    int              m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] chan_word(input int c);
        logic [NCH*WIDTH-1:0] v;
        v = in_data;
        return v[c*WIDTH +: WIDTH];
    endfunction

    // Grant according to the arbitration rules: -1 means no grant.
    function automatic int model_grant();
        if (mode == 1'b0) begin
            if (int'(sel) < NCH && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_ptr + k) % NCH;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock: check in_ready mid-cycle, advance model at the edge,
    // check registered outputs just after it.
    task automatic tick(input bit verbose);
        int g;
        bit load;
        logic [NCH-1:0] exp_rdy;
        @(negedge clk);
        g    = model_grant();
        load = !m_valid || out_ready;
        exp_rdy = '0;
        if (!rst && load && g >= 0) exp_rdy[g] = 1'b1;
        if (verbose) check("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (m_valid && out_ready) m_cnt = (m_cnt + 1) % 65536;
            if (load && g >= 0) begin
                m_valid = 1;
                m_data  = chan_word(g);
                m_chan  = g;
                m_ptr   = (g + 1) % NCH;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
        #1;
        if (verbose) begin
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("out_data",  64'(out_data),  64'(m_data));
            check("out_chan",  64'(out_chan),  64'(m_chan));
`ifdef ARB_MUX_CNT_EN
            check("xfer_cnt",  64'(xfer_cnt),  64'(m_cnt));
`endif
        end
    endtask

    task automatic rand_data();
        for (int c = 0; c < NCH; c++) in_data[c*WIDTH +: WIDTH] = $urandom;
    endtask

    task automatic drive(input logic md, input int s, input logic [NCH-1:0] v, input logic ordy);
        mode      = md;
        sel       = IW'(s);
        in_valid  = v;
        out_ready = ordy;
    endtask

    initial begin
        m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0; m_cnt = 0;
        rst = 1'b1;
        in_data = '0;
        drive(1'b0, 0, '0, 1'b0);

        // Reset state
        tick(1'b1);
        tick(1'b1);
        rst = 1'b0;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_data",  64'(out_data),  64'd0);

        // Fixed-mode pass of channel 1
        rand_data();
        in_data[1*WIDTH +: WIDTH] = 32'hA5A5A5A5;
        drive(1'b0, 1, 4'b0010, 1'b1);
        tick(1'b1);
        check("fixed_data", 64'(out_data), 64'hA5A5A5A5);
        check("fixed_chan", 64'(out_chan), 64'd1);

        // Fixed select of an idle channel grants nothing, output drains
        drive(1'b0, 3, 4'b0111, 1'b1);
        tick(1'b1);
        check("fixed_idle", 64'(out_valid), 64'd0);

        // Backpressure: fill, then stall three cycles with all valid
        rand_data();
        drive(1'b0, 2, 4'b1111, 1'b1);
        tick(1'b1);
        drive(1'b1, 0, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rand_data();
            tick(1'b1);
            check("bp_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick(1'b1);
        check("bp_release_chan", 64'(out_chan), 64'd3);

        // Round-robin fairness from a fresh pointer
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        drive(1'b1, 0, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            rand_data();
            tick(1'b1);
            check("rr_seq", 64'(out_chan), 64'(i % NCH));
            check("rr_full", 64'(out_valid), 64'd1);
        end

        // Skip/wrap: set pointer to 3 via a fixed transfer from channel 2
        drive(1'b0, 2, 4'b0100, 1'b1);
        tick(1'b1);
        drive(1'b1, 0, 4'b0101, 1'b1);
        tick(1'b1);
        check("wrap_g0", 64'(out_chan), 64'd0);
        tick(1'b1);
        check("wrap_g2", 64'(out_chan), 64'd2);
        tick(1'b1);
        check("wrap_g0b", 64'(out_chan), 64'd0);

        // No request: no grant, pointer held
        drive(1'b1, 0, 4'b0000, 1'b1);
        tick(1'b1);
        tick(1'b1);

        // Mid-operation reset while holding a word
        in_data[1*WIDTH +: WIDTH] = 32'h12345678;
        drive(1'b0, 1, 4'b0010, 1'b0);
        tick(1'b1);
        check("hold_data", 64'(out_data), 64'h12345678);
        rst = 1'b1;
        drive(1'b1, 0, 4'b1111, 1'b1);
        tick(1'b1);
        rst = 1'b0;
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_data",  64'(out_data),  64'd0);
        tick(1'b1);
        check("mrst_ptr0", 64'(out_chan), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_data();
            mode      = 1'($urandom);
            sel       = IW'($urandom);
            in_valid  = NCH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 49) == 0);
            tick(1'b1);
        end
        rst = 1'b0;

`ifdef ARB_MUX_CNT_EN
        // Counter wrap: 65535 handshakes then one more
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        drive(1'b0, 0, 4'b0001, 1'b1);
        for (int i = 0; i < 70000 && m_cnt != 65535; i++) tick(1'b0);
        check("cnt_ffff_model", 64'(m_cnt), 64'd65535);
        check("cnt_ffff", 64'(xfer_cnt), 64'hFFFF);
        tick(1'b1);
        check("cnt_wrap", 64'(xfer_cnt), 64'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_arb_mux
`default_nettype wire

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width per channel in bits.
REQ-002 The block SHALL have parameter NCH, default 4, meaning number of input channels (2..16).
REQ-003 The block SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous reset, active-high.
REQ-005 The block SHALL have port in_data, input, NCH*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have port in_valid, input, NCH, per-channel data valid.
REQ-007 The block SHALL have port in_ready, output, NCH, per-channel accept.
REQ-008 The block SHALL have port sel, input, clog2(NCH), channel select in fixed mode.
REQ-009 The block SHALL have port mode, input, 1, 0 = fixed select, 1 = round-robin.
REQ-010 The block SHALL have port out_data, output, WIDTH, registered selected data.
REQ-011 The block SHALL have port out_chan, output, clog2(NCH), source channel of out_data.
REQ-012 The block SHALL have port out_valid, output, 1, output register holds data.
REQ-013 The block SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-014 Output register SHALL be a 2-state FSM: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-015 load SHALL be defined as (out_valid==0) or (out_ready==1); input accepted only when load=1.
REQ-016 Fixed mode SHALL grant channel sel iff in_valid[sel]=1; sel >= NCH SHALL grant nothing.
REQ-017 Round-robin mode SHALL grant the first channel with in_valid=1, searching upward from rr_ptr with wrap from NCH-1 to 0.
REQ-018 in_ready[i] SHALL be 1 only when load=1 and channel i is granted; at most one bit set; combinational from current inputs and state.
REQ-019 A transfer (in_valid[g] and in_ready[g]) SHALL load in_data[g] into out_data and g into out_chan on the next edge; latency 1 cycle.
REQ-020 FSM transitions SHALL be: EMPTY to FULL on transfer; FULL to EMPTY on out_ready with no transfer; FULL stays FULL on out_ready with transfer (back-to-back, full throughput) or on out_ready=0.
REQ-021 While FULL and out_ready=0, out_data and out_chan SHALL hold stable.
REQ-022 rr_ptr SHALL update to (g+1) mod NCH on each transfer in either mode, and SHALL otherwise hold.
REQ-023 A mode or sel change SHALL affect only arbitration in the same cycle; the output register contents SHALL be unaffected.
REQ-024 No in_valid set SHALL mean no grant, no transfer, and rr_ptr unchanged.

Reset
REQ-025 On rst=1 at a rising edge: out_valid=0, out_data=0, out_chan=0, rr_ptr=0, and counter=0 if compiled.
REQ-026 Reset mid-transfer SHALL discard the held word; in_ready SHALL be 0 during any cycle where rst=1.

Configuration
REQ-027 Macro ARB_MUX_CNT_EN defined SHALL add output xfer_cnt, 16 bits, counting output handshakes (out_valid and out_ready), wrapping 0xFFFF to 0x0000.
REQ-028 Without ARB_MUX_CNT_EN, the port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-029 A shared package SHALL hold the mode encodings (MODE_FIXED=0, MODE_RR=1) and the FSM state encodings (ST_EMPTY, ST_FULL).
REQ-030 Round-robin priority selection SHALL be one sub-module, rr_pick, taking (valid vector, rr_ptr) and returning (found, index).

Verification
REQ-031 Fixed-mode pass: mode=0, sel=1, in_valid=0b0010, ch1=0xA5A5A5A5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5A5A5A5, out_chan=1.
REQ-032 Backpressure: FULL with out_ready=0 for 3 cycles, all in_valid=1 -> in_ready=0, out_data stable; out_ready=1 -> new word next cycle.
REQ-033 Round-robin fairness: mode=1, in_valid=0b1111 steady, out_ready=1 -> out_chan sequence 0,1,2,3,0, one word per cycle.
REQ-034 RR skip/wrap: rr_ptr=3, in_valid=0b0101 -> grant 0, then 2, then 0.
REQ-035 Mid-operation reset: FULL holding 0x12345678, rst=1 for one cycle -> out_valid=0, out_data=0, rr_ptr=0; with ARB_MUX_CNT_EN, xfer_cnt=0.
REQ-036 Counter wrap (ARB_MUX_CNT_EN): 65536 handshakes after reset -> xfer_cnt=0x0000; 65535 handshakes -> 0xFFFF.
